seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised Moore serial sequence detector, the configurable successor to the team's fixed-pattern detectors. It samples one bit per enabled clock and compares the most recent bits against a runtime-programmable pattern of 1..MAX_LEN bits. It raises a registered one-cycle `out` pulse per match, in overlapping or non-overlapping mode, and keeps a saturating match count. It sits on serial control/framing paths in place of hard-coded detectors; reset defaults reproduce a non-overlapping `1100` detector.

## Interface
- `MAX_LEN`, 8: longest supported pattern; ≥2.
- `CNT_W`, 8: width of `match_cnt`.
- `DEF_PAT`, 8'b0000_1100: reset pattern, right-aligned, width MAX_LEN.
- `DEF_LEN`, 4: reset pattern length; range 1..MAX_LEN.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  1  serial data bit, sampled when `en`=1.
- `en`  in  1  sample enable; when 0, state holds.
- `cfg_load`  in  1  one-cycle strobe that latches `cfg_*` into the active config.
- `cfg_pattern`  in  MAX_LEN  pattern, right-aligned; `cfg_pattern[len-1]` is the first bit expected.
- `cfg_len`  in  LEN_W  pattern length, LEN_W = $clog2(MAX_LEN+1).
- `cfg_overlap`  in  1  1 = overlapping matches allowed.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `out`  out  1  registered Moore match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `cnt_sat`  out  1  high while `match_cnt` is all-ones.

## Operation
- **Internal state:**
  - `hist[MAX_LEN-1:0]` shift register; the new bit enters `hist[0]`.
  - `fill`, 0..MAX_LEN: bits collected since the last reset, config load or non-overlap match. Saturates at MAX_LEN.
  - Active config: `pat`, `len`, `ovl`.
- **Reset** (`rst`=1 at an edge):
  - `hist`=0, `fill`=0, `pat`=DEF_PAT, `len`=DEF_LEN, `ovl`=0.
  - `out`=0, `match_cnt`=0, `cnt_sat`=0.
  - Reset overrides every other input.
- **Config load** (`cfg_load`=1, no reset):
  - Latch `pat`, `len`, `ovl` from the `cfg_*` inputs.
  - `len` clamp: 0 becomes 1; values above MAX_LEN become MAX_LEN.
  - Clear `hist` and `fill`; force `out`=0.
  - The `in`/`en` of that cycle is discarded.
  - `match_cnt` is untouched.
- **Sample step** (`en`=1, no reset, no load):
  - hist_n = {hist[MAX_LEN-2:0], in}; fill_n = min(fill+1, MAX_LEN).
  - match = (fill_n ≥ len) and (hist_n[len-1:0] == pat[len-1:0]).
  - `out` ← match.
  - On match with `ovl`=0: `fill` ← 0, so the next match needs `len` fresh bits. Otherwise `fill` ← fill_n.
  - `hist` ← hist_n in all cases.
- **Idle step** (`en`=0): `hist` and `fill` hold; `out` ← 0. Pulses never stretch.
- **Counter:**
  - `cnt_clr` zeroes the count first; a same-cycle match is then counted, so the result is 1.
  - Increments on match and saturates at 2^CNT_W−1.
  - `cnt_sat` is registered alongside `match_cnt`.
- **Changing inputs:** `cfg_*` changes without `cfg_load` have no effect.

## Timing
- **Latency:** the final pattern bit is sampled at edge k. `out`=1 and `match_cnt` updates from edge k until edge k+1.
- **Moore output:** `out` depends only on registered state, with no combinational path from `in`.
- **Throughput:**
  - Overlapping mode: back-to-back `out` pulses on consecutive cycles are legal, e.g. pattern `11`, len 2, input `111`.
  - Non-overlapping mode: minimum spacing between pulses is `len` enabled samples.
- **Reset mid-sequence:** partial match is discarded; the next match needs `len` new samples after reset release.
- **Load and enable in the same cycle:** `cfg_load` wins.

## Structure
- **Package `seq_det_pkg`:**
  - Function `len_w(max_len)`.
  - Default constants DEF_PAT and DEF_LEN.
  - Length-clamp function used by both RTL and testbench.
- **Sub-module `sat_counter`:** parameter W; ports clk, rst, clr, inc, cnt, sat. It implements the clear-then-increment priority.
- **Datapath:** masked comparison of `hist` against `pat` using a len-derived mask. No per-pattern FSM encoding.

## Test plan
- **Reset defaults:** after reset, input 1,1,0,0 → `out`=1 for exactly the cycle after the 4th sample; `match_cnt`=1.
- **Overlap on:** load pat=3'b101, len=3, ovl=1; input 1,0,1,0,1 → pulses after samples 3 and 5; `match_cnt`=2.
- **Overlap off:** same pattern with ovl=0 and the same stream → one pulse, after sample 3; `match_cnt`=1.
- **Enable gaps and clamping:**
  - Stream 1,1,0,0 with `en`=0 for two cycles between bits → one pulse after the last enabled sample; `out`=0 during the gaps.
  - `cfg_len`=0 loads as len 1.
- **Mid-sequence disruption:**
  - `rst` asserted after 1,1,0 then released, followed by 0 → no pulse.
  - `cfg_load` mid-sequence discards the partial match.
- **Counter saturation:** CNT_W=2 with 5 matches → `match_cnt` holds at 3 and `cnt_sat`=1. `cnt_clr` in the same cycle as a match → `match_cnt`=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
// The length clamp lives here so the detector and its bench agree on it.
package seq_det_pkg;

  localparam int         DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PAT     = 8'b0000_1100;
  localparam int         DEF_LEN     = 4;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Out-of-range lengths are folded into 1..max_len instead of being rejected.
  function automatic int clamp_len(input int raw, input int max_len);
    if (raw < 1) return 1;
    if (raw > max_len) return max_len;
    return raw;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. A clear and an increment in the same cycle
// leave the count at 1, because the clear is applied first.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] base;
  logic [W-1:0] cnt_n;

  always_comb begin
    base  = clr ? '0 : cnt;
    cnt_n = base;
    if (inc && (base != '1)) cnt_n = base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_n;
      sat <= (cnt_n == '1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Moore serial sequence detector with a runtime-programmable pattern of
// 1..MAX_LEN bits, optional overlap, and a saturating match counter.
module seq_detect_param
  import seq_det_pkg::len_w;
  import seq_det_pkg::clamp_len;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(seq_det_pkg::DEF_PAT),
  parameter int                 DEF_LEN = seq_det_pkg::DEF_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in,
  input  logic                      en,
  input  logic                      cfg_load,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0] cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      cnt_clr,
  output logic                      out,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      cnt_sat
);

  localparam int               LEN_W   = len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic               out_q;
  logic               match;

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], in};
    fill_n = (fill == LEN_MAX) ? fill : fill + 1'b1;
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
    match  = en && !cfg_load && (fill_n >= len) &&
             ((hist_n & mask) == (pat & mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '0;
      fill  <= '0;
      pat   <= DEF_PAT;
      len   <= LEN_RST;
      ovl   <= 1'b0;
      out_q <= 1'b0;
    end else if (cfg_load) begin
      pat   <= cfg_pattern;
      len   <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      ovl   <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
      out_q <= 1'b0;
    end else if (en) begin
      hist  <= hist_n;
      // Without overlap, a match consumes its bits; the next one needs len fresh samples.
      fill  <= (match && !ovl) ? '0 : fill_n;
      out_q <= match;
    end else begin
      out_q <= 1'b0;
    end
  end

  assign out = out_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (match),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param; a second instance with a 2-bit
// counter shares all stimulus to exercise saturation.
module tb_seq_detect_param;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = len_w(MAX_LEN);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in = 1'b0;
  logic             en = 1'b0;
  logic             cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             out, out2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;
  logic             cnt_sat, cnt_sat2;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in(in), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given bit/enable; strobes drop afterwards.
  task automatic step(input logic b, input logic e);
    in = b;
    en = e;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic sample(input logic b, input logic exp_out, input string tag);
    step(b, 1'b1);
    chk(tag, {31'd0, out}, {31'd0, exp_out});
  endtask

  task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o, input logic b);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    step(b, 1'b1);
    chk("load_out", {31'd0, out}, 32'd0);
  endtask

  initial begin
    // Reset defaults
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b0;
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("rst_sat", {31'd0, cnt_sat}, 32'd0);

    // Default non-overlapping 1100 detector
    sample(1'b1, 1'b0, "def_s1");
    sample(1'b1, 1'b0, "def_s2");
    sample(1'b0, 1'b0, "def_s3");
    sample(1'b0, 1'b1, "def_s4");
    chk("def_cnt", {24'd0, match_cnt}, 32'd1);
    step(1'b0, 1'b0);
    chk("def_no_stretch", {31'd0, out}, 32'd0);

    // Overlap on, 101
    load(8'b101, 4'd3, 1'b1, 1'b0);
    sample(1'b1, 1'b0, "ovl_s1");
    sample(1'b0, 1'b0, "ovl_s2");
    sample(1'b1, 1'b1, "ovl_s3");
    sample(1'b0, 1'b0, "ovl_s4");
    sample(1'b1, 1'b1, "ovl_s5");
    chk("ovl_cnt", {24'd0, match_cnt}, 32'd3);

    // Overlap off, same stream
    load(8'b101, 4'd3, 1'b0, 1'b0);
    sample(1'b1, 1'b0, "novl_s1");
    sample(1'b0, 1'b0, "novl_s2");
    sample(1'b1, 1'b1, "novl_s3");
    sample(1'b0, 1'b0, "novl_s4");
    sample(1'b1, 1'b0, "novl_s5");
    chk("novl_cnt", {24'd0, match_cnt}, 32'd4);

    // Enable gaps with 1100, garbage on in while idle
    load(8'b1100, 4'd4, 1'b0, 1'b0);
    sample(1'b1, 1'b0, "gap_s1");
    step(1'b0, 1'b0); step(1'b1, 1'b0);
    chk("gap_idle1", {31'd0, out}, 32'd0);
    sample(1'b1, 1'b0, "gap_s2");
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("gap_idle2", {31'd0, out}, 32'd0);
    sample(1'b0, 1'b0, "gap_s3");
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    chk("gap_idle3", {31'd0, out}, 32'd0);
    sample(1'b0, 1'b1, "gap_s4");
    step(1'b1, 1'b0);
    chk("gap_after", {31'd0, out}, 32'd0);
    chk("gap_cnt", {24'd0, match_cnt}, 32'd5);

    // Length clamp low: 0 -> 1, overlapping single-bit '1'
    load(8'b1, 4'd0, 1'b1, 1'b1);
    sample(1'b1, 1'b1, "clamp0_s1");
    sample(1'b0, 1'b0, "clamp0_s2");
    sample(1'b1, 1'b1, "clamp0_s3");
    chk("clamp0_cnt", {24'd0, match_cnt}, 32'd7);

    // Length clamp high: 15 -> 8, all ones
    load(8'hFF, 4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) sample(1'b1, 1'b0, "clamp8_early");
    sample(1'b1, 1'b1, "clamp8_s8");
    chk("clamp8_cnt", {24'd0, match_cnt}, 32'd8);

    // Back-to-back pulses: 11, len 2, overlap
    load(8'b11, 4'd2, 1'b1, 1'b0);
    sample(1'b1, 1'b0, "b2b_s1");
    sample(1'b1, 1'b1, "b2b_s2");
    sample(1'b1, 1'b1, "b2b_s3");

    // Reset mid-sequence discards 1,1,0; reset restores the 1100 default
    rst = 1'b1; step(1'b0, 1'b0); rst = 1'b0;
    sample(1'b1, 1'b0, "rmid_s1");
    sample(1'b1, 1'b0, "rmid_s2");
    sample(1'b0, 1'b0, "rmid_s3");
    rst = 1'b1; step(1'b1, 1'b1); rst = 1'b0;
    chk("rmid_cnt0", {24'd0, match_cnt}, 32'd0);
    sample(1'b0, 1'b0, "rmid_after");
    sample(1'b1, 1'b0, "rmid_r1");
    sample(1'b1, 1'b0, "rmid_r2");
    sample(1'b0, 1'b0, "rmid_r3");
    sample(1'b0, 1'b1, "rmid_r4");
    chk("rmid_cnt", {24'd0, match_cnt}, 32'd1);

    // Load mid-sequence; the loading cycle's 0 must be discarded
    sample(1'b1, 1'b0, "lmid_s1");
    sample(1'b1, 1'b0, "lmid_s2");
    load(8'b1100, 4'd4, 1'b0, 1'b0);
    sample(1'b0, 1'b0, "lmid_s3");
    // cfg changes without a load are ignored
    cfg_pattern = 8'h0F;
    cfg_len     = 4'd2;
    cfg_overlap = 1'b1;
    sample(1'b1, 1'b0, "nold_s1");
    sample(1'b1, 1'b0, "nold_s2");
    sample(1'b0, 1'b0, "nold_s3");
    sample(1'b0, 1'b1, "nold_s4");
    chk("nold_cnt", {24'd0, match_cnt}, 32'd2);

    // Saturation of the 2-bit counter
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    chk("clr_cnt", {24'd0, match_cnt}, 32'd0);
    chk("clr_cnt2", {30'd0, match_cnt2}, 32'd0);
    load(8'b1, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1, "sat_pulse");
    chk("sat_cnt2_3", {30'd0, match_cnt2}, 32'd3);
    chk("sat_flag_3", {31'd0, cnt_sat2}, 32'd1);
    sample(1'b1, 1'b1, "sat_pulse4");
    sample(1'b1, 1'b1, "sat_pulse5");
    chk("sat_cnt2_5", {30'd0, match_cnt2}, 32'd3);
    chk("sat_flag_5", {31'd0, cnt_sat2}, 32'd1);
    chk("sat_cnt8_5", {24'd0, match_cnt}, 32'd5);
    chk("sat_flag8", {31'd0, cnt_sat}, 32'd0);

    // Clear and match in the same cycle
    cnt_clr = 1'b1;
    sample(1'b1, 1'b1, "clrm_out");
    chk("clrm_cnt", {24'd0, match_cnt}, 32'd1);
    chk("clrm_cnt2", {30'd0, match_cnt2}, 32'd1);
    chk("clrm_sat2", {31'd0, cnt_sat2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
